// File: rtl/aclk_controller.sv
// Alarm-clock keypad controller: manages time/alarm entry, the display select
// and the commit pulses toward the time counter and the alarm register.
module aclk_controller #(
    parameter int unsigned TIMEOUT_S = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       one_second,
    input  logic       key_valid,
    input  logic [3:0] key_value,
    input  logic       time_button,
    input  logic       alarm_button,
    output logic       load_new_c,
    output logic       load_new_a,
    output logic       show_a,
    output logic       show_new_time,
    output logic [3:0] new_ms_hr,
    output logic [3:0] new_ls_hr,
    output logic [3:0] new_ms_min,
    output logic [3:0] new_ls_min,
    output logic       entry_error
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SHOW_ALARM = 2'd1,
        ENTRY      = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_L = 8'(TIMEOUT_S);

    state_t     state_r;
    logic [7:0] secs_r;
    logic       alarm_prev_r;

    logic       is_digit_s;
    logic       alarm_edge_s;
    logic       buf_valid_s;
    logic [7:0] secs_inc_s;

    // A buffer is a legal 24-hour time when hours are 00..23 and minutes 00..59.
    function automatic logic valid_time(input logic [3:0] mh, input logic [3:0] lh,
                                        input logic [3:0] mm, input logic [3:0] lm);
        valid_time = (mh <= 4'd2) && (lh <= 4'd9) && ((mh != 4'd2) || (lh <= 4'd3))
                     && (mm <= 4'd5) && (lm <= 4'd9);
    endfunction

    // Decode of this cycle's key, alarm edge, buffer validity and timeout step.
    always_comb begin
        is_digit_s   = key_valid && (key_value <= 4'd9);
        alarm_edge_s = alarm_button && !alarm_prev_r;
        buf_valid_s  = valid_time(new_ms_hr, new_ls_hr, new_ms_min, new_ls_min);
        secs_inc_s   = secs_r + 8'd1;
    end

    // Controller FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= IDLE;
            secs_r        <= 8'd0;
            alarm_prev_r  <= 1'b0;
            load_new_c    <= 1'b0;
            load_new_a    <= 1'b0;
            entry_error   <= 1'b0;
            show_a        <= 1'b0;
            show_new_time <= 1'b0;
            new_ms_hr     <= 4'd0;
            new_ls_hr     <= 4'd0;
            new_ms_min    <= 4'd0;
            new_ls_min    <= 4'd0;
        end else begin
            alarm_prev_r <= alarm_button;
            load_new_c   <= 1'b0;
            load_new_a   <= 1'b0;
            entry_error  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (alarm_button) begin
                        state_r       <= SHOW_ALARM;
                        show_a        <= 1'b1;
                        show_new_time <= 1'b0;
                    end else if (is_digit_s) begin
                        state_r       <= ENTRY;
                        show_a        <= 1'b0;
                        show_new_time <= 1'b1;
                        secs_r        <= 8'd0;
                        new_ms_hr     <= 4'd0;
                        new_ls_hr     <= 4'd0;
                        new_ms_min    <= 4'd0;
                        new_ls_min    <= key_value;
                    end else begin
                        show_a        <= 1'b0;
                        show_new_time <= 1'b0;
                    end
                end
                SHOW_ALARM: begin
                    if (!alarm_button) begin
                        state_r <= IDLE;
                        show_a  <= 1'b0;
                    end else begin
                        show_a  <= 1'b1;
                    end
                    show_new_time <= 1'b0;
                end
                ENTRY: begin
                    show_a <= 1'b0;
                    if (time_button) begin
                        load_new_c    <= buf_valid_s;
                        entry_error   <= !buf_valid_s;
                        state_r       <= IDLE;
                        show_new_time <= 1'b0;
                    end else if (alarm_edge_s) begin
                        load_new_a    <= buf_valid_s;
                        entry_error   <= !buf_valid_s;
                        state_r       <= IDLE;
                        show_new_time <= 1'b0;
                    end else if (is_digit_s) begin
                        new_ms_hr  <= new_ls_hr;
                        new_ls_hr  <= new_ms_min;
                        new_ms_min <= new_ls_min;
                        new_ls_min <= key_value;
                        secs_r     <= 8'd0;
                    end else if (one_second) begin
                        secs_r <= secs_inc_s;
                        if (secs_inc_s >= TIMEOUT_L) begin
                            state_r       <= IDLE;
                            show_new_time <= 1'b0;
                        end else begin
                            show_new_time <= 1'b1;
                        end
                    end else begin
                        show_new_time <= 1'b1;
                    end
                end
                default: begin
                    state_r       <= IDLE;
                    show_a        <= 1'b0;
                    show_new_time <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aclk_controller.sv
// Bench for aclk_controller: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the entry rules.
module tb_aclk_controller;

    localparam int TMO = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       one_second = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_value = 4'd0;
    logic       time_button = 1'b0;
    logic       alarm_button = 1'b0;
    logic       load_new_c, load_new_a, show_a, show_new_time, entry_error;
    logic [3:0] new_ms_hr, new_ls_hr, new_ms_min, new_ls_min;

    int errors = 0;
    int checks = 0;

    // Model: mode 0 = idle, 1 = alarm shown, 2 = entering; digits as a queue.
    int mode = 0;
    int dq[$] = '{0, 0, 0, 0};
    int secs = 0;
    bit prev_alarm = 1'b0;
    bit exp_c = 1'b0, exp_a = 1'b0, exp_err = 1'b0;

    aclk_controller #(.TIMEOUT_S(TMO)) dut (
        .clk(clk), .reset(reset), .one_second(one_second), .key_valid(key_valid),
        .key_value(key_value), .time_button(time_button), .alarm_button(alarm_button),
        .load_new_c(load_new_c), .load_new_a(load_new_a), .show_a(show_a),
        .show_new_time(show_new_time), .new_ms_hr(new_ms_hr), .new_ls_hr(new_ls_hr),
        .new_ms_min(new_ms_min), .new_ls_min(new_ls_min), .entry_error(entry_error)
    );

    always #5 clk = ~clk;

    function automatic bit legal_time(input int d[$]);
        int hh = 10 * d[0] + d[1];
        int mm = 10 * d[2] + d[3];
        return (hh < 24) && (mm < 60);
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit edge_a = alarm_button && !prev_alarm;
        bit digit = key_valid && (key_value < 4'd10);
        exp_c = 0; exp_a = 0; exp_err = 0;
        if (reset) begin
            mode = 0; dq = '{0, 0, 0, 0}; secs = 0; prev_alarm = 0;
            return;
        end
        prev_alarm = alarm_button;
        if (mode == 0) begin
            if (alarm_button) mode = 1;
            else if (digit) begin dq = '{0, 0, 0, int'(key_value)}; secs = 0; mode = 2; end
        end else if (mode == 1) begin
            if (!alarm_button) mode = 0;
        end else begin
            if (time_button) begin
                if (legal_time(dq)) exp_c = 1; else exp_err = 1;
                mode = 0;
            end else if (edge_a) begin
                if (legal_time(dq)) exp_a = 1; else exp_err = 1;
                mode = 0;
            end else if (digit) begin
                void'(dq.pop_front());
                dq.push_back(int'(key_value));
                secs = 0;
            end else if (one_second) begin
                secs++;
                if (secs >= TMO) mode = 0;
            end
        end
    endtask

    // One clock: model consumes the inputs seen at the edge, outputs checked 1ns later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("load_new_c", int'(load_new_c), int'(exp_c));
        check("load_new_a", int'(load_new_a), int'(exp_a));
        check("entry_error", int'(entry_error), int'(exp_err));
        check("show_a", int'(show_a), int'(mode == 1));
        check("show_new_time", int'(show_new_time), int'(mode == 2));
        check("new_ms_hr", int'(new_ms_hr), dq[0]);
        check("new_ls_hr", int'(new_ls_hr), dq[1]);
        check("new_ms_min", int'(new_ms_min), dq[2]);
        check("new_ls_min", int'(new_ls_min), dq[3]);
        one_second = 0; key_valid = 0; time_button = 0;
    endtask

    task automatic key(input int d);
        key_valid = 1; key_value = 4'(d);
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic keys4(input int a, input int b, input int c, input int d);
        key(a); key(b); key(c); key(d);
    endtask

    initial begin
        reset = 1; idle(2);
        check("reset_show_new_time", int'(show_new_time), 0);
        reset = 0; idle(1);

        // 1,2,3,4 + time commit
        keys4(1, 2, 3, 4);
        time_button = 1; tick();
        check("d1234_load_c", int'(load_new_c), 1);
        check("d1234_buf", int'({new_ms_hr, new_ls_hr, new_ms_min, new_ls_min}), 16'h1234);
        idle(2);

        // invalid 24:00, then alarm 23:59 held
        keys4(2, 4, 0, 0);
        time_button = 1; tick();
        check("d2400_err", int'(entry_error), 1);
        idle(1);
        keys4(2, 3, 5, 9);
        alarm_button = 1; tick();
        check("d2359_load_a", int'(load_new_a), 1);
        idle(3);
        check("d2359_show_a", int'(show_a), 1);
        alarm_button = 0; idle(2);

        // five digits, oldest discarded
        keys4(1, 2, 3, 4); key(5);
        time_button = 1; tick();
        check("d5dig_buf", int'({new_ms_hr, new_ls_hr, new_ms_min, new_ls_min}), 16'h2345);
        idle(1);

        // timeout with non-digit key mid-way
        key(7);
        for (int s = 0; s < TMO; s++) begin
            idle(1);
            if (s == TMO / 2) begin key_valid = 1; key_value = 4'd12; end
            one_second = 1; tick();
        end
        check("timeout_idle", int'(show_new_time), 0);
        idle(2);

        // time button beats alarm edge; then reset beats both
        keys4(0, 9, 3, 0);
        time_button = 1; alarm_button = 1; tick();
        check("prio_load_c", int'(load_new_c), 1);
        alarm_button = 0; idle(2);
        keys4(0, 9, 3, 0);
        time_button = 1; reset = 1; tick();
        check("reset_commit_c", int'(load_new_c), 0);
        reset = 0; idle(1);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 199) == 0);
            one_second = ($urandom_range(0, 5) == 0);
            key_valid = ($urandom_range(0, 2) == 0);
            key_value = 4'($urandom_range(0, 15));
            time_button = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 9) == 0) alarm_button = ~alarm_button;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aclk_controller.md
ACLK_CONTROLLER -- requirements
Module: aclk_controller

Interface
REQ-001 SHALL have parameter: TIMEOUT_S, 10, number of one_second pulses without a digit key before abandoning entry (legal range 1..255).
REQ-002 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port: reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: one_second  input  1  single-cycle pulse, once per second.
REQ-005 SHALL have port: key_valid  input  1  single-cycle keypad strobe.
REQ-006 SHALL have port: key_value  input  4  keypad code; 0..9 digit, 10..15 non-digit.
REQ-007 SHALL have port: time_button  input  1  single-cycle pulse, commit entry as current time.
REQ-008 SHALL have port: alarm_button  input  1  level, high while pressed.
REQ-009 SHALL have port: load_new_c  output  1  one-cycle pulse, load buffer into time counter.
REQ-010 SHALL have port: load_new_a  output  1  one-cycle pulse, load buffer into alarm register.
REQ-011 SHALL have port: show_a  output  1  display selects alarm time.
REQ-012 SHALL have port: show_new_time  output  1  display selects entry buffer.
REQ-013 SHALL have port: new_ms_hr, new_ls_hr, new_ms_min, new_ls_min  output  4 each  entry buffer digits.
REQ-014 SHALL have port: entry_error  output  1  one-cycle pulse, commit rejected as invalid time.

Function
REQ-015 SHALL implement FSM states IDLE, SHOW_ALARM, ENTRY; all outputs registered.
REQ-016 IDLE: show_a=0, show_new_time=0; alarm_button high -> SHOW_ALARM; else key_valid with digit -> ENTRY; non-digit keys, time_button ignored.
REQ-017 SHOW_ALARM: show_a=1; alarm_button low -> IDLE; keys and time_button ignored.
REQ-018 IDLE->ENTRY on digit d SHALL set buffer to {0,0,0,d} in the same transition.
REQ-019 ENTRY: show_new_time=1; each digit key SHALL shift buffer left (ms_hr<-ls_hr<-ms_min<-ls_min<-d), discarding old ms_hr.
REQ-020 Timeout counter SHALL clear on ENTRY entry and on every digit key; increment on one_second in ENTRY; reaching TIMEOUT_S -> IDLE, no load, no error.
REQ-021 Non-digit keys SHALL be ignored and SHALL NOT clear the timeout counter.
REQ-022 Alarm commit edge = alarm_button high and registered previous sample low.
REQ-023 ENTRY event priority per cycle: time_button > alarm edge > digit key > timeout.
REQ-024 Valid time: ms_hr<=2, ls_hr<=9, (ms_hr==2 -> ls_hr<=3), ms_min<=5, ls_min<=9; checked on buffer value at commit cycle.
REQ-025 time_button in ENTRY: valid -> load_new_c=1 next cycle; invalid -> entry_error=1 next cycle; both -> IDLE.
REQ-026 Alarm edge in ENTRY: valid -> load_new_a=1 next cycle; invalid -> entry_error=1; both -> IDLE (then SHOW_ALARM next if button still held).
REQ-027 new_* outputs SHALL hold buffer value through and after commit until next IDLE->ENTRY transition.
REQ-028 load_new_c, load_new_a, entry_error SHALL never be high together and SHALL each last exactly one cycle.
REQ-029 show_a and show_new_time SHALL never be high together.

Reset
REQ-030 reset high at a clock edge SHALL force IDLE, buffer 0000, timeout counter 0, alarm edge register 0, all outputs 0, overriding every other input including mid-entry and mid-commit.
REQ-031 Pulse of a commit scheduled for the cycle reset is sampled SHALL be suppressed.

Verification
REQ-032 Keys 1,2,3,4 then time_button -> new_*=1,2,3,4, load_new_c pulse 1 cycle later, show_new_time drops, state IDLE.
REQ-033 Keys 2,4,0,0 then time_button -> entry_error pulse, no load_new_c; keys 2,3,5,9 + alarm_button rise -> load_new_a pulse, then show_a=1 while held.
REQ-034 Keys 1..5 (five digits) then time_button -> buffer 2,3,4,5, load_new_c pulse.
REQ-035 Key 7 then TIMEOUT_S one_second pulses with no digit (non-digit key 12 mid-way) -> IDLE at TIMEOUT_S-th pulse, no pulses output.
REQ-036 time_button and alarm rise in same ENTRY cycle with 0,9,3,0 -> only load_new_c; reset asserted same cycle -> no pulse, all outputs 0.
